// File: rtl/mc_pkg.sv
// Shared types and helpers for the multi-client round-robin arbiter.
// State encoding and a constant-foldable clog2.
package mc_pkg;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_ISSUE = 1'b1
  } state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/mc_tag_fifo.sv
// In-order tag FIFO remembering which requester owns each in-flight request.
// Power-of-two depth, so pointers wrap by natural overflow.
module mc_tag_fifo
  import mc_pkg::*;
#(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 2,
  localparam int PW    = clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] head_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_q, wr_d;
  logic [PW-1:0]    rd_q, rd_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (push_i) wr_d = wr_q + PW'(1);
    if (pop_i)  rd_d = rd_q + PW'(1);
    if (push_i && !pop_i) cnt_d = cnt_q + CW'(1);
    if (pop_i && !push_i) cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (push_i) mem_q[wr_q] <= din_i;
  end

  assign head_o  = mem_q[rd_q];
  assign count_o = cnt_q;

endmodule

// File: rtl/mc_rr_arbiter.sv
// Round-robin arbiter funnelling N requesters onto one master port,
// routing in-order responses back by a tag FIFO.
module mc_rr_arbiter
  import mc_pkg::*;
#(
  parameter  int ADDR_WIDTH      = 32,
  parameter  int DATA_WIDTH      = 32,
  parameter  int CONNECT_NUM     = 3,
  parameter  int MAX_OUTSTANDING = 4,
  localparam int GW              = clog2(CONNECT_NUM),
  localparam int OW              = clog2(MAX_OUTSTANDING) + 1
) (
  input  logic                            CLK,
  input  logic                            RST,
  input  logic [CONNECT_NUM-1:0]          SLAVE_RECEIVE_ADDR_VALID,
  input  logic [ADDR_WIDTH*CONNECT_NUM-1:0] SLAVE_RECEIVE_ADDR,
  input  logic [CONNECT_NUM-1:0]          SLAVE_RECEIVE_DATA_VALID,
  input  logic [DATA_WIDTH*CONNECT_NUM-1:0] SLAVE_RECEIVE_DATA,
  output logic [CONNECT_NUM-1:0]          SLAVE_RECEIVE_READY,
  output logic [CONNECT_NUM-1:0]          SLAVE_SEND_VALID,
  output logic [DATA_WIDTH*CONNECT_NUM-1:0] SLAVE_SEND_DATA,
  input  logic [CONNECT_NUM-1:0]          SLAVE_SEND_READY,
  output logic                            MASTER_SEND_ADDR_VALID,
  output logic [ADDR_WIDTH-1:0]           MASTER_SEND_ADDR,
  output logic                            MASTER_SEND_DATA_VALID,
  output logic [DATA_WIDTH-1:0]           MASTER_SEND_DATA,
  input  logic                            MASTER_SEND_READY,
  input  logic                            MASTER_RECEIVE_VALID,
  input  logic [DATA_WIDTH-1:0]           MASTER_RECEIVE_DATA,
  output logic                            MASTER_RECEIVE_READY,
  output logic [OW-1:0]                   OUTSTANDING,
  output logic                            ERR_UNEXPECTED
);

  state_e        state_q, state_d;
  logic [GW-1:0] grant_q, grant_d;
  logic [GW-1:0] last_q, last_d;
  logic [GW-1:0] pick;
  logic          pick_vld;
  logic          push, pop;
  logic [GW-1:0] head;
  logic [OW-1:0] count;
  logic          err_q, err_d;

  // Rotating priority: scan upward from the slot after the last winner.
  always_comb begin
    int j;
    j        = 0;
    pick     = '0;
    pick_vld = 1'b0;
    for (int i = 1; i <= CONNECT_NUM; i++) begin
      j = int'(last_q) + i;
      if (j >= CONNECT_NUM) j = j - CONNECT_NUM;
      if (!pick_vld && SLAVE_RECEIVE_ADDR_VALID[j]) begin
        pick     = GW'(j);
        pick_vld = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      last_q  <= GW'(CONNECT_NUM - 1);
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    push    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (pick_vld && count < OW'(MAX_OUTSTANDING)) begin
          grant_d = pick;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (MASTER_SEND_READY) begin
          last_d  = grant_q;
          push    = 1'b1;
          state_d = S_IDLE;
        end
      end
    endcase
  end

  always_comb begin
    MASTER_SEND_ADDR_VALID = 1'b0;
    MASTER_SEND_DATA_VALID = 1'b0;
    MASTER_SEND_ADDR =
      SLAVE_RECEIVE_ADDR[int'(grant_q)*ADDR_WIDTH +: ADDR_WIDTH];
    MASTER_SEND_DATA =
      SLAVE_RECEIVE_DATA[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
    SLAVE_RECEIVE_READY  = '0;
    SLAVE_SEND_VALID     = '0;
    SLAVE_SEND_DATA      = '0;
    MASTER_RECEIVE_READY = 1'b0;
    if (!RST && state_q == S_ISSUE) begin
      MASTER_SEND_ADDR_VALID       = 1'b1;
      MASTER_SEND_DATA_VALID       = SLAVE_RECEIVE_DATA_VALID[grant_q];
      SLAVE_RECEIVE_READY[grant_q] = MASTER_SEND_READY;
    end
    if (!RST && count != '0) begin
      SLAVE_SEND_VALID[head] = MASTER_RECEIVE_VALID;
      SLAVE_SEND_DATA[int'(head)*DATA_WIDTH +: DATA_WIDTH] =
        MASTER_RECEIVE_DATA;
      MASTER_RECEIVE_READY = SLAVE_SEND_READY[head];
    end
  end

  assign pop   = MASTER_RECEIVE_VALID & MASTER_RECEIVE_READY;
  assign err_d = err_q | (MASTER_RECEIVE_VALID && count == '0);

  mc_tag_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (GW)
  ) u_fifo (
    .CLK     (CLK),
    .RST     (RST),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (grant_q),
    .head_o  (head),
    .count_o (count)
  );

  assign OUTSTANDING    = count;
  assign ERR_UNEXPECTED = err_q;

endmodule

// File: tb/tb_mc_rr_arbiter.sv
// Directed bench for mc_rr_arbiter: a per-cycle vector table plus
// hand-written sequences for rotation, stalls, limits and reset.
module tb_mc_rr_arbiter;

  logic        CLK;
  logic        RST;
  logic [2:0]  av, dv, srr, ssv, ssr;
  logic [95:0] raddr, rdata, sdata;
  logic        mav, mdv, mrdy, rv, mrr, err;
  logic [31:0] maddr, mdata, rd;
  logic [2:0]  outs;

  int n_chk;
  int n_fail;

  mc_rr_arbiter dut (
    .CLK                      (CLK),
    .RST                      (RST),
    .SLAVE_RECEIVE_ADDR_VALID (av),
    .SLAVE_RECEIVE_ADDR       (raddr),
    .SLAVE_RECEIVE_DATA_VALID (dv),
    .SLAVE_RECEIVE_DATA       (rdata),
    .SLAVE_RECEIVE_READY      (srr),
    .SLAVE_SEND_VALID         (ssv),
    .SLAVE_SEND_DATA          (sdata),
    .SLAVE_SEND_READY         (ssr),
    .MASTER_SEND_ADDR_VALID   (mav),
    .MASTER_SEND_ADDR         (maddr),
    .MASTER_SEND_DATA_VALID   (mdv),
    .MASTER_SEND_DATA         (mdata),
    .MASTER_SEND_READY        (mrdy),
    .MASTER_RECEIVE_VALID     (rv),
    .MASTER_RECEIVE_DATA      (rd),
    .MASTER_RECEIVE_READY     (mrr),
    .OUTSTANDING              (outs),
    .ERR_UNEXPECTED           (err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [2:0]  av;
    logic [2:0]  dv;
    logic        mrdy;
    logic        rv;
    logic [31:0] rd;
    logic [2:0]  ssr;
    logic        e_mav;
    logic [31:0] e_maddr;
    logic        e_mdv;
    logic [2:0]  e_srr;
    logic [2:0]  e_out;
    logic [2:0]  e_ssv;
    logic [95:0] e_sdata;
    logic        e_mrr;
  } vec_t;

  vec_t tbl[13];

  task automatic chk(input string nm, input logic [95:0] act,
                     input logic [95:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic nxt;
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic [2:0] a, input logic [2:0] d,
                       input logic m, input logic v,
                       input logic [31:0] r, input logic [2:0] s);
    av   = a;
    dv   = d;
    mrdy = m;
    rv   = v;
    rd   = r;
    ssr  = s;
  endtask

  task automatic do_reset;
    RST = 1'b1;
    drive(3'b000, 3'b000, 1'b0, 1'b0, 32'h0, 3'b111);
    nxt;
    nxt;
    RST = 1'b0;
  endtask

  function automatic vec_t mk(
    input logic [2:0] a, input logic [2:0] d, input logic m,
    input logic v, input logic [31:0] r, input logic [2:0] s,
    input logic emav, input logic [31:0] eaddr, input logic emdv,
    input logic [2:0] esrr, input logic [2:0] eout,
    input logic [2:0] essv, input logic [95:0] esd, input logic emrr);
    vec_t t;
    t.av = a; t.dv = d; t.mrdy = m; t.rv = v; t.rd = r; t.ssr = s;
    t.e_mav = emav; t.e_maddr = eaddr; t.e_mdv = emdv;
    t.e_srr = esrr; t.e_out = eout; t.e_ssv = essv;
    t.e_sdata = esd; t.e_mrr = emrr;
    return t;
  endfunction

  initial begin
    n_chk  = 0;
    n_fail = 0;
    for (int i = 0; i < 3; i++) begin
      raddr[i*32 +: 32] = 32'h100 * (i + 1);
      rdata[i*32 +: 32] = 32'hD0 + i;
    end

    // Single request, then ordered return to requesters 2 and 0.
    tbl[0]  = mk(3'b001, 3'b001, 1, 0, 0, 3'b111,
                 0, 0, 0, 3'b000, 0, 3'b000, 96'h0, 0);
    tbl[1]  = mk(3'b001, 3'b001, 1, 0, 0, 3'b111,
                 1, 32'h100, 1, 3'b001, 0, 3'b000, 96'h0, 0);
    tbl[2]  = mk(3'b000, 3'b000, 1, 0, 0, 3'b111,
                 0, 0, 0, 3'b000, 1, 3'b000, 96'h0, 1);
    tbl[3]  = mk(3'b000, 3'b000, 1, 1, 32'h55, 3'b111,
                 0, 0, 0, 3'b000, 1, 3'b001, {64'h0, 32'h55}, 1);
    tbl[4]  = mk(3'b000, 3'b000, 1, 0, 0, 3'b111,
                 0, 0, 0, 3'b000, 0, 3'b000, 96'h0, 0);
    tbl[5]  = mk(3'b100, 3'b000, 1, 0, 0, 3'b111,
                 0, 0, 0, 3'b000, 0, 3'b000, 96'h0, 0);
    tbl[6]  = mk(3'b100, 3'b000, 1, 0, 0, 3'b111,
                 1, 32'h300, 0, 3'b100, 0, 3'b000, 96'h0, 0);
    tbl[7]  = mk(3'b001, 3'b001, 1, 0, 0, 3'b111,
                 0, 0, 0, 3'b000, 1, 3'b000, 96'h0, 1);
    tbl[8]  = mk(3'b001, 3'b001, 1, 0, 0, 3'b111,
                 1, 32'h100, 1, 3'b001, 1, 3'b000, 96'h0, 1);
    tbl[9]  = mk(3'b000, 3'b000, 1, 1, 32'hAA, 3'b011,
                 0, 0, 0, 3'b000, 2, 3'b100, {32'hAA, 64'h0}, 0);
    tbl[10] = mk(3'b000, 3'b000, 1, 1, 32'hAA, 3'b111,
                 0, 0, 0, 3'b000, 2, 3'b100, {32'hAA, 64'h0}, 1);
    tbl[11] = mk(3'b000, 3'b000, 1, 1, 32'hBB, 3'b111,
                 0, 0, 0, 3'b000, 1, 3'b001, {64'h0, 32'hBB}, 1);
    tbl[12] = mk(3'b000, 3'b000, 1, 0, 0, 3'b111,
                 0, 0, 0, 3'b000, 0, 3'b000, 96'h0, 0);

    do_reset;
    #1;
    chk("rst_out", 96'(outs), 96'd0);
    chk("rst_err", 96'(err), 96'd0);
    chk("rst_mav", 96'(mav), 96'd0);
    chk("rst_srr", 96'(srr), 96'd0);
    chk("rst_ssv", 96'(ssv), 96'd0);
    chk("rst_mrr", 96'(mrr), 96'd0);

    for (int k = 0; k < 13; k++) begin
      drive(tbl[k].av, tbl[k].dv, tbl[k].mrdy, tbl[k].rv,
            tbl[k].rd, tbl[k].ssr);
      #1;
      chk($sformatf("v%0d_mav", k), 96'(mav), 96'(tbl[k].e_mav));
      if (tbl[k].e_mav)
        chk($sformatf("v%0d_addr", k), 96'(maddr), 96'(tbl[k].e_maddr));
      chk($sformatf("v%0d_mdv", k), 96'(mdv), 96'(tbl[k].e_mdv));
      chk($sformatf("v%0d_srr", k), 96'(srr), 96'(tbl[k].e_srr));
      chk($sformatf("v%0d_out", k), 96'(outs), 96'(tbl[k].e_out));
      chk($sformatf("v%0d_ssv", k), 96'(ssv), 96'(tbl[k].e_ssv));
      chk($sformatf("v%0d_sdata", k), sdata, tbl[k].e_sdata);
      chk($sformatf("v%0d_mrr", k), 96'(mrr), 96'(tbl[k].e_mrr));
      nxt;
    end

    // All three requesting: grants rotate 0,1,2,0,1,2.
    do_reset;
    for (int k = 0; k < 12; k++) begin
      if (k % 2 == 0) begin
        drive(3'b111, 3'b000, 1, k > 0, 32'h0, 3'b111);
        #1;
        chk($sformatf("rr%0d_idle", k), 96'(mav), 96'd0);
      end else begin
        drive(3'b111, 3'b000, 1, 0, 32'h0, 3'b111);
        #1;
        chk($sformatf("rr%0d_mav", k), 96'(mav), 96'd1);
        chk($sformatf("rr%0d_addr", k), 96'(maddr),
            96'(32'h100 * ((k / 2) % 3 + 1)));
      end
      nxt;
    end
    chk("rr_err", 96'(err), 96'd0);

    // Master stalls five cycles in issue.
    do_reset;
    drive(3'b010, 3'b000, 0, 0, 32'h0, 3'b111);
    #1;
    chk("st_idle", 96'(mav), 96'd0);
    nxt;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("st%0d_mav", k), 96'(mav), 96'd1);
      chk($sformatf("st%0d_addr", k), 96'(maddr), 96'h200);
      chk($sformatf("st%0d_srr", k), 96'(srr), 96'd0);
      chk($sformatf("st%0d_out", k), 96'(outs), 96'd0);
      nxt;
    end
    drive(3'b000, 3'b000, 1, 0, 32'h0, 3'b111);
    #1;
    chk("st_rel_srr", 96'(srr), 96'b010);
    chk("st_rel_addr", 96'(maddr), 96'h200);
    nxt;
    #1;
    chk("st_out", 96'(outs), 96'd1);
    chk("st_mav", 96'(mav), 96'd0);

    // Outstanding limit blocks a fifth request until one pops.
    do_reset;
    drive(3'b001, 3'b001, 1, 0, 32'h0, 3'b111);
    for (int k = 0; k < 8; k++) nxt;
    #1;
    chk("lim_out4", 96'(outs), 96'd4);
    chk("lim_mav0", 96'(mav), 96'd0);
    nxt;
    #1;
    chk("lim_blk", 96'(mav), 96'd0);
    drive(3'b001, 3'b001, 1, 1, 32'h77, 3'b111);
    #1;
    chk("lim_mrr", 96'(mrr), 96'd1);
    nxt;
    drive(3'b001, 3'b001, 1, 0, 32'h0, 3'b111);
    #1;
    chk("lim_out3", 96'(outs), 96'd3);
    chk("lim_idle", 96'(mav), 96'd0);
    nxt;
    #1;
    chk("lim_grant", 96'(mav), 96'd1);

    // Unexpected response, then reset with two in flight.
    do_reset;
    drive(3'b000, 3'b000, 1, 1, 32'h99, 3'b111);
    #1;
    chk("ux_ssv", 96'(ssv), 96'd0);
    chk("ux_mrr", 96'(mrr), 96'd0);
    nxt;
    drive(3'b001, 3'b001, 1, 0, 32'h0, 3'b111);
    #1;
    chk("ux_err", 96'(err), 96'd1);
    for (int k = 0; k < 4; k++) nxt;
    #1;
    chk("ux_out2", 96'(outs), 96'd2);
    chk("ux_sticky", 96'(err), 96'd1);
    drive(3'b001, 3'b001, 0, 0, 32'h0, 3'b111);
    nxt;
    #1;
    chk("ux_issue", 96'(mav), 96'd1);
    RST = 1'b1;
    #1;
    chk("ux_rst_mav", 96'(mav), 96'd0);
    chk("ux_rst_srr", 96'(srr), 96'd0);
    nxt;
    RST = 1'b0;
    drive(3'b000, 3'b000, 1, 0, 32'h0, 3'b111);
    #1;
    chk("ux_rst_out", 96'(outs), 96'd0);
    chk("ux_rst_err", 96'(err), 96'd0);
    chk("ux_rst_mav2", 96'(mav), 96'd0);
    drive(3'b000, 3'b000, 1, 1, 32'h44, 3'b111);
    #1;
    chk("ux_late_ssv", 96'(ssv), 96'd0);
    nxt;
    drive(3'b000, 3'b000, 1, 0, 32'h0, 3'b111);
    #1;
    chk("ux_late_err", 96'(err), 96'd1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mc_rr_arbiter.md
MC_RR_ARBITER -- requirements
Module: mc_rr_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, request address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, write/read data width.
REQ-003 SHALL have parameter CONNECT_NUM, default 3, number of requesters (2..8).
REQ-004 SHALL have parameter MAX_OUTSTANDING, default 4, in-flight request limit (power of 2, 2..16).
REQ-005 SHALL have ports: CLK in 1 clock; RST in 1 reset, synchronous, active-high (clock CLK).
REQ-006 SHALL have ports: SLAVE_RECEIVE_ADDR_VALID in CONNECT_NUM; SLAVE_RECEIVE_ADDR in ADDR_WIDTH*CONNECT_NUM; SLAVE_RECEIVE_DATA_VALID in CONNECT_NUM (write qualifier); SLAVE_RECEIVE_DATA in DATA_WIDTH*CONNECT_NUM; SLAVE_RECEIVE_READY out CONNECT_NUM.
REQ-007 SHALL have ports: SLAVE_SEND_VALID out CONNECT_NUM; SLAVE_SEND_DATA out DATA_WIDTH*CONNECT_NUM; SLAVE_SEND_READY in CONNECT_NUM.
REQ-008 SHALL have ports: MASTER_SEND_ADDR_VALID out 1; MASTER_SEND_ADDR out ADDR_WIDTH; MASTER_SEND_DATA_VALID out 1; MASTER_SEND_DATA out DATA_WIDTH; MASTER_SEND_READY in 1.
REQ-009 SHALL have ports: MASTER_RECEIVE_VALID in 1; MASTER_RECEIVE_DATA in DATA_WIDTH; MASTER_RECEIVE_READY out 1; OUTSTANDING out clog2(MAX_OUTSTANDING)+1 current count; ERR_UNEXPECTED out 1 sticky.

Function
REQ-010 SHALL implement states S_IDLE and S_ISSUE.
REQ-011 In S_IDLE, when any ADDR_VALID is high and OUTSTANDING < MAX_OUTSTANDING, SHALL register grant index and enter S_ISSUE next cycle; otherwise stay S_IDLE.
REQ-012 Grant SHALL be round-robin: search starts at (last_grant+1) mod CONNECT_NUM, first valid requester wins; last_grant resets to CONNECT_NUM-1 (index 0 has first priority).
REQ-013 In S_ISSUE, MASTER_SEND_ADDR_VALID SHALL be 1 and MASTER_SEND_ADDR/DATA/DATA_VALID SHALL mirror the granted requester combinationally.
REQ-014 In S_ISSUE, SLAVE_RECEIVE_READY[grant] SHALL equal MASTER_SEND_READY; all other READY bits 0; all READY bits 0 in S_IDLE.
REQ-015 Grant SHALL not change while in S_ISSUE; on master handshake (VALID&READY) SHALL update last_grant, push grant index into tag FIFO, return to S_IDLE.
REQ-016 Arbitration latency: request visible cycle t -> MASTER_SEND_ADDR_VALID at t+1; sustained throughput 1 request per 2 cycles.
REQ-017 Requesters SHALL hold VALID and payload stable until READY; behaviour if they drop VALID in S_ISSUE is undefined (arbiter keeps issuing).
REQ-018 Responses SHALL return in issue order; head of tag FIFO selects destination.
REQ-019 With OUTSTANDING>0: SLAVE_SEND_VALID[head]=MASTER_RECEIVE_VALID, SLAVE_SEND_DATA slice[head]=MASTER_RECEIVE_DATA, MASTER_RECEIVE_READY=SLAVE_SEND_READY[head]; other VALID bits 0; pop on handshake.
REQ-020 With OUTSTANDING=0: MASTER_RECEIVE_READY=0, all SLAVE_SEND_VALID 0; MASTER_RECEIVE_VALID high here SHALL set ERR_UNEXPECTED (sticky until RST).
REQ-021 Simultaneous push and pop SHALL leave OUTSTANDING unchanged; push never occurs when full (guaranteed by REQ-011).
REQ-022 SLAVE_SEND_DATA slices of non-selected requesters SHALL drive 0.
REQ-023 Every request (read or write) SHALL produce exactly one response.

Reset
REQ-024 RST SHALL force S_IDLE, last_grant=CONNECT_NUM-1, FIFO empty, OUTSTANDING=0, ERR_UNEXPECTED=0; all VALID/READY outputs 0 in the reset cycle and after.
REQ-025 RST mid-operation SHALL drop in-flight tags; later responses count as unexpected.

Structure
REQ-026 Package mc_pkg SHALL hold state encoding (S_IDLE=0, S_ISSUE=1) and the clog2 helper.
REQ-027 Tag FIFO SHALL be sub-module mc_tag_fifo (depth MAX_OUTSTANDING, width clog2(CONNECT_NUM), push/pop/count, wrap-around pointers).

Verification
REQ-028 Req0 only, addr 0x100, master ready=1 -> MASTER_SEND_ADDR_VALID cycle t+1, READY[0] pulse, OUTSTANDING=1.
REQ-029 All 3 requesters hold valid, master always ready -> grants 0,1,2,0,1,2 in order.
REQ-030 Master ready held 0 for 5 cycles during S_ISSUE -> address stable, grant unchanged, no push.
REQ-031 Issue 4 requests, no responses -> 5th not granted; one response popped -> 5th granted next S_IDLE cycle.
REQ-032 Requests from 2 then 0, responses 0xAA, 0xBB -> 0xAA to requester 2, 0xBB to requester 0; SLAVE_SEND_READY[2]=0 stalls MASTER_RECEIVE_READY.
REQ-033 MASTER_RECEIVE_VALID with OUTSTANDING=0, then RST with 2 in flight -> ERR_UNEXPECTED=1; after RST OUTSTANDING=0, ERR_UNEXPECTED=0.
